// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants: ROB/data widths, the broadcast packet
// consumed by the ROB and reservation-station wakeup, and a pointer helper.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU_DEFAULT = 4;
    localparam int unsigned ROB_IDX_W      = 3;
    localparam int unsigned DATA_W         = 32;

    // One CDB broadcast: destination ROB entry and its result value.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    value;
    } cdb_packet_t;

    // Round-robin successor of slot k among n slots.
    function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-to-arbiter result handshake plus the registered CDB broadcast.
// The arbiter takes the slave view; FUs / bench take the master view.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU    = NUM_FU_DEFAULT,
    parameter int unsigned ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W,
    parameter int unsigned DATA_W    = cdb_arbiter_pkg::DATA_W
);
    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]                fu_valid_in;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx_in;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_value_in;
    logic [NUM_FU-1:0]                fu_ready_out;

    logic                             cdb_valid_out;
    logic [ROB_IDX_W-1:0]             cdb_rob_idx_out;
    logic [DATA_W-1:0]                cdb_value_out;
    logic [SRC_W-1:0]                 cdb_src_out;

    modport master (
        output fu_valid_in, fu_rob_idx_in, fu_value_in,
        input  fu_ready_out,
        input  cdb_valid_out, cdb_rob_idx_out, cdb_value_out, cdb_src_out
    );

    modport slave (
        input  fu_valid_in, fu_rob_idx_in, fu_value_in,
        output fu_ready_out,
        output cdb_valid_out, cdb_rob_idx_out, cdb_value_out, cdb_src_out
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr
// (wrapping modulo N) wins; produces a one-hot grant and its encoded index.
module rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter  int unsigned N = NUM_FU_DEFAULT,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any_grant
);

    int unsigned pos;
    logic [W-1:0] pos_w;

    // Scan from ptr upward with wraparound; the first hit locks the grant.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        pos       = 0;
        pos_w     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            pos   = (32'(ptr) + off) % N;
            pos_w = W'(pos);
            if (!any_grant && req[pos_w]) begin
                grant[pos_w] = 1'b1;
                idx          = pos_w;
                any_grant    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: each FU owns a one-entry holding slot; one held slot per
// cycle is granted round-robin and broadcast on registered CDB outputs.
// A slot drained by a grant may be refilled at the same edge.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU    = NUM_FU_DEFAULT,
    parameter int unsigned ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W,
    parameter int unsigned DATA_W    = cdb_arbiter_pkg::DATA_W
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush_in,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned SRC_W = $clog2(NUM_FU);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    value;
    } slot_t;

    logic [NUM_FU-1:0]    held;
    slot_t                slot [NUM_FU];
    logic [SRC_W-1:0]     rr_ptr;

    logic [NUM_FU-1:0]    grant;
    logic [SRC_W-1:0]     grant_idx;
    logic                 any_grant;
    logic [NUM_FU-1:0]    ready;
    logic [NUM_FU-1:0]    accept;

    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [DATA_W-1:0]    cdb_value;
    logic [SRC_W-1:0]     cdb_src;

    // Arbitration looks only at held slots; new inputs never bypass to the CDB.
    rr_pick #(.N(NUM_FU)) u_pick (
        .req       (held),
        .ptr       (rr_ptr),
        .grant     (grant),
        .idx       (grant_idx),
        .any_grant (any_grant)
    );

    // A slot is ready when empty or draining this cycle; reset and flush block all.
    always_comb begin
        ready  = (rst_in || flush_in) ? '0 : (~held | grant);
        accept = bus.fu_valid_in & ready;
    end

    assign bus.fu_ready_out    = ready;
    assign bus.cdb_valid_out   = cdb_valid;
    assign bus.cdb_rob_idx_out = cdb_rob_idx;
    assign bus.cdb_value_out   = cdb_value;
    assign bus.cdb_src_out     = cdb_src;

    // Slot payload capture; accept is already gated by reset/flush via ready.
    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot[i] <= '{rob_idx: bus.fu_rob_idx_in[i], value: bus.fu_value_in[i]};
            end
        end
    end

    // Occupancy, round-robin pointer and registered CDB broadcast.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            held        <= '0;
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_rob_idx <= '0;
            cdb_value   <= '0;
            cdb_src     <= '0;
        end else if (flush_in) begin
            held      <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else begin
            // Refill wins over drain so a granted slot can take a new result.
            held      <= (held & ~grant) | accept;
            cdb_valid <= any_grant;
            if (any_grant) begin
                cdb_rob_idx <= slot[grant_idx].rob_idx;
                cdb_value   <= slot[grant_idx].value;
                cdb_src     <= grant_idx;
                rr_ptr      <= SRC_W'(rr_next(32'(grant_idx), NUM_FU));
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) among NUM_FU functional units.
- Each FU delivers a completed result (ROB index and value) through a one-entry holding buffer.
- One buffered result per cycle is granted round-robin and broadcast on a registered CDB output.
- The CDB output drives ROB writeback and operand wakeup in the reservation stations.

Parameters:
- NUM_FU, 4, number of requesting functional units (at least 2).
- ROB_IDX_W, 3, ROB entry index width (ROB size 8).
- DATA_W, 32, result value width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- flush_in  in  1  pipeline flush (mispredict); discards all buffered results.
- fu_valid_in  in  NUM_FU  per-FU result valid.
- fu_rob_idx_in  in  NUM_FU x ROB_IDX_W  per-FU destination ROB index.
- fu_value_in  in  NUM_FU x DATA_W  per-FU result value.
- fu_ready_out  out  NUM_FU  per-FU holding slot can accept this cycle (combinational).
- cdb_valid_out  out  1  CDB broadcast valid; high for exactly one cycle per grant.
- cdb_rob_idx_out  out  ROB_IDX_W  broadcast ROB index.
- cdb_value_out  out  DATA_W  broadcast value.
- cdb_src_out  out  clog2(NUM_FU)  index of the FU that won the grant.

Behaviour:
- State:
  - held[i] valid bit plus a rob_idx/value register per FU.
  - rr_ptr of clog2(NUM_FU) bits.
  - Registered CDB outputs.
- Reset (rst_in high at an edge):
  - held clears to all 0; rr_ptr to 0.
  - cdb_valid_out, cdb_rob_idx_out, cdb_value_out and cdb_src_out all go to 0.
  - fu_ready_out is forced to 0 while rst_in is high.
  - Reset has priority over flush and over all other activity.
- Ready:
  - fu_ready_out[i] = !rst_in && !flush_in && (!held[i] || grant[i]).
  - A granted slot may therefore be refilled at the same edge it drains.
- Accept: on an edge with fu_valid_in[i] && fu_ready_out[i], the slot captures fu_rob_idx_in[i] and fu_value_in[i] and sets held[i].
  - fu_valid_in while not ready is ignored. The FU must hold its result and retry.
- Arbitration:
  - Combinational over the held entries only; there is no input-to-CDB bypass.
  - Search order is rr_ptr, rr_ptr+1, … mod NUM_FU. The first held entry wins, giving a one-hot grant.
  - On a grant to k: the CDB registers load slot k; cdb_src_out <= k; cdb_valid_out <= 1; held[k] clears unless it is refilled at the same edge; rr_ptr <= (k+1) mod NUM_FU.
  - No held entries: cdb_valid_out <= 0; the data/src outputs hold their last value; rr_ptr is unchanged.
- Latency:
  - A result accepted at edge E appears on the CDB after edge E+1 at the earliest, i.e. minimum 2 cycles from fu_valid_in to cdb_valid_out.
  - Worst case, with all slots held, a buffered result is granted within NUM_FU cycles (starvation-free).
- Throughput: one broadcast per cycle while any slot is held.
- Flush (flush_in high at an edge):
  - held clears to all 0; cdb_valid_out <= 0; rr_ptr <= 0.
  - fu_ready_out is 0, so same-cycle inputs are dropped.
  - No grant is issued in the flush cycle.
- Simultaneous events:
  - Grant of k and a new accept on k at the same edge: the slot holds the new result and rr_ptr advances past k.
  - Accepts on multiple FUs in the same cycle are all captured.
- Duplicate ROB indices are not checked; the block passes them through in grant order.

Decomposition:
- Add to the shared types package (hdl/types.svh):
  - Constants ROB_IDX_W and DATA_W.
  - typedef struct packed cdb_packet_t {rob_idx, value}, reused by the ROB and reservation-station wakeup logic.
- Sub-module rr_pick: purely combinational, NUM_FU-wide, request vector + pointer -> one-hot grant + encoded index + any_grant.
  - Unit-tested standalone and instantiated once here.

Test Plan:
- Single request: after reset, FU1 sends rob 5 / value 0x0000_00AA for one cycle -> cdb_valid_out high exactly once, 2 cycles later, with rob 5, value 0xAA, src 1; fu_ready_out[1] stays 1 throughout.
- Fairness: all 4 FUs present results in the same cycle (rob 0..3, values 10..13) -> four consecutive broadcasts in src order 0,1,2,3; then FUs 0 and 2 request again -> order 0,2 (rr_ptr=0 after src 3).
- Back-to-back and refill: FU2 holds valid high continuously with values 1,2,3,… and no competitors -> one broadcast per cycle, values in order, no gaps, fu_ready_out[2] constantly 1.
- Backpressure: FU0 and FU3 stream continuously -> alternating grants 0,3,0,3; each fu_ready_out is 1 only in its grant cycle; no result is lost or duplicated (scoreboard check).
- Flush: three slots held and flush_in pulsed for one cycle together with a new FU1 request -> no CDB broadcast in the following cycle; held is empty; the FU1 request is dropped; the next request from FU2 is granted first after rr_ptr reset to 0.
- Reset mid-operation: rst_in asserted while slots are held and cdb_valid_out=1 -> after the edge, all outputs are 0 and fu_ready_out is 0 during reset; after release, a new FU0 request is broadcast normally.
